// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch_sel N-way 4-phase splitter.
package branch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int N_OUT_DEF = 4;
  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 16;

  // Channel index width for a given number of outputs (never below 1 bit).
  function automatic int ch_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_width(N_OUT_DEF);

endpackage

// File: rtl/branch_dec.sv
// Enable-gated binary-to-one-hot decoder; purely combinational.
module branch_dec
  import branch_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int DEC_W = ch_width(N_OUT)
) (
  input  logic [DEC_W-1:0] ch_i,
  input  logic             en_i,
  output logic [N_OUT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot_o[i] = en_i && (ch_i == DEC_W'(i));
    end
  end

endmodule

// File: rtl/branch_sel.sv
// N-way 4-phase request splitter with registered outputs and completion counter.
// BRANCH_SEL_DEFAULT_EN: out-of-range sel routes to the last channel instead of flagging err.
module branch_sel
  import branch_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [SEL_W-1:0] sel,
  input  logic [N_OUT-1:0] ack_in,
  output logic [N_OUT-1:0] fin,
  output logic             ack_out,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int M_CH_W = ch_width(N_OUT);
  // One extra bit so N_OUT itself is representable for the range compare.
  localparam logic [SEL_W:0] N_OUT_S = (SEL_W + 1)'(N_OUT);
`ifdef BRANCH_SEL_DEFAULT_EN
  localparam logic [M_CH_W-1:0] LAST_CH = M_CH_W'(N_OUT - 1);
`endif

  state_e              state_q, state_d;
  logic [M_CH_W-1:0]   ch_q, ch_d;
  logic [N_OUT-1:0]    fin_q, fin_d;
  logic                ack_out_q, ack_out_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                sel_ok;
  logic                ack_sel;

  assign sel_ok  = {1'b0, sel} < N_OUT_S;
  assign ack_sel = ack_in[ch_q];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    ack_out_d = ack_out_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (sel_ok) begin
            ch_d    = sel[M_CH_W-1:0];
            state_d = ST_ISSUE;
          end else begin
`ifdef BRANCH_SEL_DEFAULT_EN
            ch_d    = LAST_CH;
            state_d = ST_ISSUE;
`else
            // Acknowledge upstream straight away so a bad selector cannot stall it.
            ch_d      = '0;
            err_d     = 1'b1;
            ack_out_d = 1'b1;
            state_d   = ST_DONE;
`endif
          end
        end
      end
      ST_ISSUE: begin
        if (ack_sel) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_sel) begin
          ack_out_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!req) begin
          ack_out_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they appear on the deciding edge.
  branch_dec #(
    .N_OUT (N_OUT),
    .DEC_W (M_CH_W)
  ) u_dec (
    .ch_i     (ch_d),
    .en_i     (state_d == ST_ISSUE),
    .onehot_o (fin_d)
  );

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      fin_q     <= '0;
      ack_out_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      fin_q     <= fin_d;
      ack_out_q <= ack_out_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign fin     = fin_q;
  assign ack_out = ack_out_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign txn_cnt = cnt_q;

endmodule

// File: tb/tb_branch_sel.sv
// Bench for branch_sel: table vectors, corner sequences and random transactions.
module tb_branch_sel;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 4 channels, 3-bit selector (4..7 out of range), 4-bit counter.
  logic       a_req;
  logic [2:0] a_sel;
  logic [3:0] a_ack;
  logic [3:0] a_fin;
  logic       a_ack_out, a_busy, a_err;
  logic [3:0] a_cnt;

  // DUT B: 3 channels, 2-bit selector (3 out of range).
  logic        b_req;
  logic [1:0]  b_sel;
  logic [2:0]  b_ack;
  logic [2:0]  b_fin;
  logic        b_ack_out, b_busy, b_err;
  logic [15:0] b_cnt;

  branch_sel #(.N_OUT(4), .SEL_W(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(a_req), .sel(a_sel), .ack_in(a_ack),
    .fin(a_fin), .ack_out(a_ack_out), .busy(a_busy), .err(a_err), .txn_cnt(a_cnt)
  );

  branch_sel #(.N_OUT(3), .SEL_W(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .req(b_req), .sel(b_sel), .ack_in(b_ack),
    .fin(b_fin), .ack_out(b_ack_out), .busy(b_busy), .err(b_err), .txn_cnt(b_cnt)
  );

  int checks   = 0;
  int failures = 0;
  logic [3:0]  a_exp_cnt;
  logic [15:0] b_exp_cnt;

  typedef struct {
    int         sel;
    logic [3:0] noise;
    int         d_ack;
    int         d_rel;
    bit         drop;
    logic [3:0] exp_fin;
    bit         exp_oor;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level view of the routing rules.
  function automatic logic [3:0] model_fin(input int s);
    logic [3:0] one = 4'b0001;
    if (s < 4) return one << s;
`ifdef BRANCH_SEL_DEFAULT_EN
    return 4'b1000;
`else
    return 4'b0000;
`endif
  endfunction

  function automatic bit model_oor(input int s);
`ifdef BRANCH_SEL_DEFAULT_EN
    return 1'b0;
`else
    return s >= 4;
`endif
  endfunction

  // One full 4-phase transaction on DUT A; noise drives unselected ack bits.
  task automatic run_a(input int s, input logic [3:0] noise, input int d_ack, input int d_rel,
                       input bit drop, input logic [3:0] exp_fin, input bit exp_oor, input string tag);
    a_req = 1'b1;
    a_sel = 3'(s);
    a_ack = noise & ~exp_fin;
    step();
    if (exp_oor) begin
      chk({tag, " oor err"}, a_err, 1);
      chk({tag, " oor ack_out"}, a_ack_out, 1);
      chk({tag, " oor fin"}, a_fin, 0);
      chk({tag, " oor busy"}, a_busy, 1);
      a_req = 1'b0;
      a_ack = '0;
      step();
      chk({tag, " oor err clr"}, a_err, 0);
      chk({tag, " oor ack_out clr"}, a_ack_out, 0);
      chk({tag, " oor cnt"}, a_cnt, a_exp_cnt);
      return;
    end
    chk({tag, " fin issue"}, a_fin, exp_fin);
    chk({tag, " busy issue"}, a_busy, 1);
    chk({tag, " err issue"}, a_err, 0);
    for (int i = 0; i < d_ack; i++) begin
      a_sel = 3'($urandom);
      if (drop) a_req = 1'b0;
      a_ack = noise & ~exp_fin;
      step();
      chk({tag, " fin hold"}, a_fin, exp_fin);
    end
    a_req = 1'b1;
    a_sel = 3'($urandom);
    a_ack = (noise & ~exp_fin) | exp_fin;
    step();
    chk({tag, " fin clr"}, a_fin, 0);
    chk({tag, " ack_out release"}, a_ack_out, 0);
    for (int i = 0; i < d_rel; i++) begin
      a_ack = (noise & ~exp_fin) | exp_fin;
      step();
      chk({tag, " ack_out wait"}, a_ack_out, 0);
    end
    a_ack = noise & ~exp_fin;
    step();
    a_exp_cnt = a_exp_cnt + 4'd1;
    chk({tag, " ack_out done"}, a_ack_out, 1);
    chk({tag, " cnt"}, a_cnt, a_exp_cnt);
    chk({tag, " fin done"}, a_fin, 0);
    a_ack = '0;
    step();
    chk({tag, " ack_out hold"}, a_ack_out, 1);
    a_req = 1'b0;
    step();
    chk({tag, " ack_out clr"}, a_ack_out, 0);
    chk({tag, " busy idle"}, a_busy, 0);
  endtask

  initial begin
    tbl[0] = '{2, 4'b0000, 0, 0, 1'b0, 4'b0100, 1'b0};
    tbl[1] = '{1, 4'b1101, 2, 1, 1'b0, 4'b0010, 1'b0};
    tbl[2] = '{0, 4'b1110, 1, 0, 1'b1, 4'b0001, 1'b0};
    tbl[3] = '{3, 4'b0111, 0, 2, 1'b0, 4'b1000, 1'b0};
`ifdef BRANCH_SEL_DEFAULT_EN
    tbl[4] = '{5, 4'b0101, 1, 1, 1'b0, 4'b1000, 1'b0};
    tbl[5] = '{7, 4'b0000, 0, 0, 1'b1, 4'b1000, 1'b0};
`else
    tbl[4] = '{5, 4'b0101, 1, 1, 1'b0, 4'b0000, 1'b1};
    tbl[5] = '{7, 4'b0000, 0, 0, 1'b1, 4'b0000, 1'b1};
`endif
    tbl[6] = '{2, 4'b1011, 3, 3, 1'b1, 4'b0100, 1'b0};

    rst = 1'b1;
    a_req = 1'b0; a_sel = '0; a_ack = '0;
    b_req = 1'b0; b_sel = '0; b_ack = '0;
    repeat (3) step();
    chk("reset fin", a_fin, 0);
    chk("reset ack_out", a_ack_out, 0);
    chk("reset busy", a_busy, 0);
    chk("reset err", a_err, 0);
    chk("reset cnt", a_cnt, 0);
    chk("reset b fin", b_fin, 0);
    chk("reset b cnt", b_cnt, 0);
    rst = 1'b0;
    a_exp_cnt = '0;
    b_exp_cnt = '0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_a(tbl[i].sel, tbl[i].noise, tbl[i].d_ack, tbl[i].d_rel, tbl[i].drop,
            tbl[i].exp_fin, tbl[i].exp_oor, $sformatf("vec%0d", i));
    end

    // Reset while channel 3 is being requested aborts without a count.
    a_req = 1'b1; a_sel = 3'd3; a_ack = '0;
    step();
    chk("midrst fin before", a_fin, 4'b1000);
    rst = 1'b1;
    step();
    chk("midrst fin", a_fin, 0);
    chk("midrst ack_out", a_ack_out, 0);
    chk("midrst busy", a_busy, 0);
    chk("midrst err", a_err, 0);
    chk("midrst cnt", a_cnt, 0);
    rst = 1'b0; a_req = 1'b0;
    a_exp_cnt = '0;
    b_exp_cnt = '0;
    step();
    run_a(0, 4'b0000, 1, 1, 1'b0, 4'b0001, 1'b0, "post_rst");

    // Counter wrap: 16 back-to-back transactions from zero.
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      int s;
      s = int'($urandom_range(0, 3));
      run_a(s, 4'($urandom), 0, 0, 1'b0, model_fin(s), 1'b0, "wrap");
    end
    chk("wrap cnt zero", a_cnt, 0);

    for (int i = 0; i < 40; i++) begin
      int s;
      s = int'($urandom_range(0, 7));
      run_a(s, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), model_fin(s), model_oor(s), "rand");
    end

    // DUT B: selector 3 with only three channels.
    b_req = 1'b1; b_sel = 2'd3; b_ack = '0;
    step();
`ifdef BRANCH_SEL_DEFAULT_EN
    chk("b oor fin", b_fin, 3'b100);
    chk("b oor err", b_err, 0);
    b_ack = 3'b100;
    step();
    chk("b oor fin clr", b_fin, 0);
    b_ack = 3'b000;
    step();
    b_exp_cnt = b_exp_cnt + 16'd1;
    chk("b oor ack_out", b_ack_out, 1);
    chk("b oor cnt", b_cnt, b_exp_cnt);
`else
    chk("b oor err", b_err, 1);
    chk("b oor ack_out", b_ack_out, 1);
    chk("b oor fin", b_fin, 0);
    chk("b oor cnt", b_cnt, b_exp_cnt);
`endif
    b_req = 1'b0;
    step();
    chk("b oor ack_out clr", b_ack_out, 0);
    chk("b oor err clr", b_err, 0);
    chk("b oor busy", b_busy, 0);

    b_req = 1'b1; b_sel = 2'd1; b_ack = 3'b101;
    step();
    chk("b fin", b_fin, 3'b010);
    b_sel = 2'd2;
    b_ack = 3'b111;
    step();
    chk("b fin clr", b_fin, 0);
    b_ack = 3'b101;
    step();
    b_exp_cnt = b_exp_cnt + 16'd1;
    chk("b ack_out", b_ack_out, 1);
    chk("b cnt", b_cnt, b_exp_cnt);
    b_req = 1'b0;
    step();
    chk("b idle", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
